// File: rtl/roll_button.sv
// roll_button: debounced, lockout-limited roll request front end.
// Defining ROLL_BUTTON_AUTOREPEAT_EN adds hold-to-auto-repeat.
module roll_button #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
    parameter logic [15:0] LOCKOUT_CYCLES  = 16'd13000
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = 24'd4000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd2000000
`endif
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN,
    output logic       ROLL,
    output logic       PRESSED,
    output logic       BUSY,
    output logic [7:0] ROLL_CNT
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lock_q, lock_d;
    logic        roll_q, roll_d;
    logic        pressed_q, pressed_d;
    logic        busy_q;
    logic [7:0]  roll_cnt_q, roll_cnt_d;
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
    logic [23:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        roll_d    = 1'b0;
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
                rep_d = '0;
`endif
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
                    roll_d    = !busy_q;
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
                    rep_d     = REPEAT_DELAY;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
                // A skipped repeat (busy) still reloads so the cadence is kept.
                if (rep_q <= 24'd1) begin
                    rep_d  = REPEAT_PERIOD;
                    roll_d = !busy_q && !roll_q;
                end else begin
                    rep_d = rep_q - 24'd1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = HELD;
                end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        lock_d     = roll_d ? LOCKOUT_CYCLES : (lock_q != '0 ? lock_q - 16'd1 : lock_q);
        roll_cnt_d = roll_cnt_q + {7'd0, roll_q};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            cnt_q      <= '0;
            lock_q     <= '0;
            roll_q     <= 1'b0;
            pressed_q  <= 1'b0;
            busy_q     <= 1'b0;
            roll_cnt_q <= '0;
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s1_q       <= BTN;
            s2_q       <= s1_q;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            roll_q     <= roll_d;
            pressed_q  <= pressed_d;
            busy_q     <= (lock_q != '0);
            roll_cnt_q <= roll_cnt_d;
`ifdef ROLL_BUTTON_AUTOREPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign ROLL     = roll_q;
    assign PRESSED  = pressed_q;
    assign BUSY     = busy_q;
    assign ROLL_CNT = roll_cnt_q;
endmodule
